// File: rtl/sort8_stream.sv
// Streaming 8-entry sorter: accepts eight values by in-place insertion, then
// streams them out in ascending order, each tagged with its arrival index.
module sort8_stream #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDXW  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_last,
   output logic             busy
);

   localparam int unsigned N  = 8;
   localparam int unsigned CW = 4;

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [IDXW-1:0]  rp_q, rp_d;
   logic [WIDTH-1:0] val_q [N];
   logic [WIDTH-1:0] val_d [N];
   logic [IDXW-1:0]  idx_q [N];
   logic [IDXW-1:0]  idx_d [N];
   logic [N-1:0]     le;
   logic [N-1:0]     le_prev;

   // Occupied entries at or below the incoming value; contiguous prefix since the array is sorted.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         le[i] = (CW'(i) < count_q) && (val_q[i] <= in_data);
      end
      le_prev = {le[N-2:0], 1'b1};
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rp_d      = rp_q;
      val_d     = val_q;
      idx_d     = idx_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_idx   = '0;
      out_last  = 1'b0;

      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // Slot p is the first position not <= in_data; everything above p moves up one.
               for (int i = 0; i < N; i++) begin
                  if (!le[i] && le_prev[i]) begin
                     val_d[i] = in_data;
                     idx_d[i] = IDXW'(count_q);
                  end
               end
               for (int i = 1; i < N; i++) begin
                  if (!le[i] && !le_prev[i]) begin
                     val_d[i] = val_q[i-1];
                     idx_d[i] = idx_q[i-1];
                  end
               end
               count_d = count_q + CW'(1);
               if (count_q == CW'(N-1)) begin
                  state_d = DRAIN;
                  rp_d    = '0;
               end
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_data  = val_q[rp_q];
            out_idx   = idx_q[rp_q];
            out_last  = (rp_q == IDXW'(N-1));
            if (out_ready) begin
               rp_d = rp_q + IDXW'(1);
               if (rp_q == IDXW'(N-1)) begin
                  state_d = FILL;
                  count_d = '0;
                  rp_d    = '0;
               end
            end
         end
         default: state_d = FILL;
      endcase

      // Abort overrides any accept or output transfer in the same cycle.
      if (clear) begin
         state_d = FILL;
         count_d = '0;
         rp_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         count_q <= '0;
         rp_q    <= '0;
         for (int i = 0; i < N; i++) begin
            val_q[i] <= '0;
            idx_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rp_q    <= rp_d;
         val_q   <= val_d;
         idx_q   <= idx_d;
      end
   end

   assign busy = (count_q != '0) || (state_q == DRAIN);

endmodule

// File: tb/tb_sort8_stream.sv
// Scoreboard bench for sort8_stream: expected sorted order is computed by rank
// counting when a batch is fed and compared as outputs transfer.
module tb_sort8_stream;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_idx;
   logic       out_last;
   logic       busy;

   typedef struct {
      logic [7:0] d;
      logic [2:0] i;
      logic       l;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   sort8_stream #(.WIDTH(8), .IDXW(3)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stable ascending order by rank: count smaller values plus equal values that arrived earlier.
   task automatic model_push(input logic [7:0] v [8]);
      exp_t tmp [8];
      for (int i = 0; i < 8; i++) begin
         int rank = 0;
         for (int j = 0; j < 8; j++) begin
            if (v[j] < v[i] || (v[j] == v[i] && j < i)) rank++;
         end
         tmp[rank].d = v[i];
         tmp[rank].i = 3'(i);
         tmp[rank].l = 1'b0;
      end
      tmp[7].l = 1'b1;
      for (int k = 0; k < 8; k++) sb.push_back(tmp[k]);
   endtask

   task automatic feed(input logic [7:0] v [8], input int gap);
      model_push(v);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = v[i];
         step();
         in_valid = 1'b0;
         if (i < 7) repeat (gap) step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
      end else passed++;
      total++;
      if (out_data !== 8'h00 || out_idx !== 3'd0 || out_last !== 1'b0) begin
         $display("FAIL reset_data: out_data=%h out_idx=%0d out_last=%b, expected 00 0 0", out_data, out_idx, out_last);
      end else passed++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [7:0] b [8];
      exp_t e;
      b = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
      out_ready = 1'b1;
      feed(b, 0);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL basic_valid k=%0d: out_valid=%b, expected 1", k, out_valid);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_idx !== e.i || out_last !== e.l)
               $display("FAIL basic_out k=%0d: got %0d/%0d/%b, expected %0d/%0d/%b", k, out_data, out_idx, out_last, e.d, e.i, e.l);
            else passed++;
         end
         step();
      end
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL basic_after: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
      end else passed++;
   endtask

   task automatic test_duplicates();
      logic [7:0] b [8];
      exp_t e;
      b = '{8'h07, 8'h07, 8'h00, 8'h07, 8'h00, 8'hFF, 8'h00, 8'h07};
      out_ready = 1'b1;
      feed(b, 0);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL dup_valid k=%0d: out_valid=%b, expected 1", k, out_valid);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_idx !== e.i || out_last !== e.l)
               $display("FAIL dup_out k=%0d: got %h/%0d/%b, expected %h/%0d/%b", k, out_data, out_idx, out_last, e.d, e.i, e.l);
            else passed++;
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] b [8];
      exp_t e;
      b = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
      out_ready = 1'b1;
      feed(b, 0);
      repeat (2) begin
         if (out_valid === 1'b1 && sb.size() != 0) void'(sb.pop_front());
         step();
      end
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 8'h00;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== sb[0].d || out_idx !== sb[0].i) begin
            $display("FAIL stall c=%0d: valid=%b in_ready=%b data=%0d idx=%0d, expected 1 0 %0d %0d",
                     c, out_valid, in_ready, out_data, out_idx, sb[0].d, sb[0].i);
         end else passed++;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 2; k < 8; k++) begin
         total++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL bp_valid k=%0d: out_valid=%b, expected 1", k, out_valid);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_idx !== e.i || out_last !== e.l)
               $display("FAIL bp_out k=%0d: got %0d/%0d/%b, expected %0d/%0d/%b", k, out_data, out_idx, out_last, e.d, e.i, e.l);
            else passed++;
         end
         step();
      end
   endtask

   task automatic test_sparse_back_to_back();
      logic [7:0] b [8];
      exp_t e;
      b = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
      out_ready = 1'b1;
      feed(b, 2);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL sparse_valid k=%0d: out_valid=%b, expected 1", k, out_valid);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_idx !== e.i || out_last !== e.l)
               $display("FAIL sparse_out k=%0d: got %0d/%0d/%b, expected %0d/%0d/%b", k, out_data, out_idx, out_last, e.d, e.i, e.l);
            else passed++;
         end
         step();
      end
      total++;
      if (in_ready !== 1'b1) $display("FAIL sparse_ready: in_ready=%b, expected 1", in_ready);
      else passed++;
      b = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      feed(b, 0);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL b2b_valid k=%0d: out_valid=%b, expected 1", k, out_valid);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_idx !== e.i || out_last !== e.l)
               $display("FAIL b2b_out k=%0d: got %0d/%0d/%b, expected %0d/%0d/%b", k, out_data, out_idx, out_last, e.d, e.i, e.l);
            else passed++;
         end
         step();
      end
   endtask

   task automatic test_clear();
      logic [7:0] b [8];
      exp_t e;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(10 * (i + 1));
         step();
      end
      in_data = 8'h00;
      clear   = 1'b1;
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         $display("FAIL clear_pre: in_ready=%b busy=%b, expected 1 1", in_ready, busy);
      end else passed++;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      total++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         $display("FAIL clear_post: busy=%b in_ready=%b out_valid=%b, expected 0 1 0", busy, in_ready, out_valid);
      end else passed++;
      b = '{8'hFF, 8'h80, 8'h01, 8'h00, 8'h7F, 8'h81, 8'hFE, 8'h02};
      feed(b, 0);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL clr_valid k=%0d: out_valid=%b, expected 1", k, out_valid);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_idx !== e.i || out_last !== e.l)
               $display("FAIL clr_out k=%0d: got %h/%0d/%b, expected %h/%0d/%b", k, out_data, out_idx, out_last, e.d, e.i, e.l);
            else passed++;
         end
         step();
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] b [8];
      exp_t e;
      b = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
      out_ready = 1'b1;
      feed(b, 0);
      for (int k = 0; k < 5; k++) begin
         total++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL ar_valid k=%0d: out_valid=%b, expected 1", k, out_valid);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_idx !== e.i)
               $display("FAIL ar_out k=%0d: got %0d/%0d, expected %0d/%0d", k, out_data, out_idx, e.d, e.i);
            else passed++;
         end
         step();
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
         $display("FAIL async_rst: out_valid=%b busy=%b in_ready=%b out_last=%b, expected 0 0 1 0", out_valid, busy, in_ready, out_last);
      end else passed++;
      sb.delete();
      #1;
      rst_n = 1'b1;
      step();
      b = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd10, 8'd0, 8'd50, 8'd30};
      feed(b, 0);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL post_rst_valid k=%0d: out_valid=%b, expected 1", k, out_valid);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_idx !== e.i || out_last !== e.l)
               $display("FAIL post_rst_out k=%0d: got %0d/%0d/%b, expected %0d/%0d/%b", k, out_data, out_idx, out_last, e.d, e.i, e.l);
            else passed++;
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_duplicates();
      test_backpressure();
      test_sparse_back_to_back();
      test_clear();
      test_async_reset();
      total++;
      if (sb.size() != 0) $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
